// File: rtl/mem_top.sv
// mem_top: memory-access pipeline stage. Runs word loads/stores over the shared
// bus via a req/grant/ready master FSM, flags misaligned accesses, and
// produces the MEM/WB register plus a combinational forwarding value.
module mem_top (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  input  logic [29:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [31:0] ex_out,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic [31:0] fwd_data,
  output logic [29:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACCESS, ST_STALL} state_t;

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br_flag;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst_addr;
    logic        gpr_we_;
    logic [2:0]  exp_code;
    logic [31:0] out;
  } mem_wb_t;

  localparam logic [1:0] MEM_OP_LDW     = 2'd1;
  localparam logic [1:0] MEM_OP_STW     = 2'd2;
  localparam logic [2:0] EXP_NONE       = 3'd0;
  localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;

  localparam mem_wb_t MEM_WB_CLEAR = '{pc: 30'd0, en: 1'b0, br_flag: 1'b0,
                                       ctrl_op: 2'd0, dst_addr: 5'd0, gpr_we_: 1'b1,
                                       exp_code: 3'd0, out: 32'd0};

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_as_q, bus_as_d;
  logic        bus_rw_q, bus_rw_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  logic access_valid;
  logic miss_align;
  logic bus_request;

  // Classify the instruction sitting in EX/MEM: memory access, misaligned, or bus-worthy
  always_comb begin
    access_valid = ex_en && (ex_exp_code == EXP_NONE) &&
                   ((ex_mem_op == MEM_OP_LDW) || (ex_mem_op == MEM_OP_STW));
    miss_align   = access_valid && (ex_out[1:0] != 2'b00);
    bus_request  = access_valid && !miss_align && !flush;
  end

  // Bus-master next state, registered bus strobes, busy and forwarding mux
  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    bus_req_d     = 1'b1;
    bus_as_d      = 1'b1;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    fwd_data      = ex_out;
    case (state_q)
      ST_IDLE: begin
        if (bus_request) begin
          bus_req_d = 1'b0;
          busy      = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          busy      = 1'b1;
          bus_req_d = 1'b0;
          if (!bus_grnt_) begin
            bus_as_d      = 1'b0;
            bus_rw_d      = (ex_mem_op == MEM_OP_LDW);
            bus_addr_d    = ex_out[31:2];
            bus_wr_data_d = ex_mem_wr_data;
            state_d       = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!bus_rdy_) begin
          rd_buf_d = bus_rd_data;
          if (bus_rw_q) begin
            fwd_data = bus_rd_data;
          end
          state_d = stall ? ST_STALL : ST_IDLE;
        end else begin
          busy      = 1'b1;
          bus_req_d = 1'b0;
        end
      end
      ST_STALL: begin
        if (bus_rw_q) begin
          fwd_data = rd_buf_q;
        end
        if (!stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM/WB update: stall holds, flush clears, misaligned raises MISS_ALIGN
  always_comb begin
    mem_wb_d = mem_wb_q;
    if (!stall) begin
      if (flush) begin
        mem_wb_d = MEM_WB_CLEAR;
      end else begin
        mem_wb_d.pc       = ex_pc;
        mem_wb_d.en       = ex_en;
        mem_wb_d.br_flag  = ex_br_flag;
        mem_wb_d.ctrl_op  = ex_ctrl_op;
        mem_wb_d.dst_addr = ex_dst_addr;
        mem_wb_d.gpr_we_  = ex_gpr_we_;
        mem_wb_d.exp_code = ex_exp_code;
        mem_wb_d.out      = fwd_data;
        if (miss_align) begin
          mem_wb_d.exp_code = EXP_MISS_ALIGN;
          mem_wb_d.gpr_we_  = 1'b1;
        end
      end
    end
  end

  // State, bus output and read-buffer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= 30'd0;
      bus_wr_data_q <= 32'd0;
      rd_buf_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb_q <= MEM_WB_CLEAR;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus_req_     = bus_req_q;
  assign bus_as_      = bus_as_q;
  assign bus_rw       = bus_rw_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wr_data  = bus_wr_data_q;
  assign mem_pc       = mem_wb_q.pc;
  assign mem_en       = mem_wb_q.en;
  assign mem_br_flag  = mem_wb_q.br_flag;
  assign mem_ctrl_op  = mem_wb_q.ctrl_op;
  assign mem_dst_addr = mem_wb_q.dst_addr;
  assign mem_gpr_we_  = mem_wb_q.gpr_we_;
  assign mem_exp_code = mem_wb_q.exp_code;
  assign mem_out      = mem_wb_q.out;

endmodule
